// File: rtl/lbm_frame_streamer.sv
// ---------------------------------------------------------------------------
// lbm_frame_streamer
//
// Captures per-cell macroscopic solver outputs (one beat of NUM_CH packed
// channel samples per cell) and streams whole frames over AXI4-Stream
// through an internal beat FIFO.
//
// Features:
//   - frame decimation: stream one frame, then skip `decim` frames
//   - per-channel masking: a disabled lane is zeroed and its strobes cleared
//   - tlast on the last cell (DEPTH-1) of every streamed frame
//   - sticky overflow flag when a captured cell finds the FIFO full
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   en                capture enable (gates frame_start / cell_valid)
//   decim             frames to skip after each streamed frame
//   ch_mask           per-channel enable, sampled at push time
//   frame_start       1-cycle pulse at the start of each solver step
//   cell_valid        a cell is presented on cell_data
//   cell_data         packed channel samples, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*          AXI4-Stream master (tvalid/tdata/tstrb/tlast/tready)
//   busy              FSM active or beats still buffered / pending on output
//   overflow          sticky: at least one captured cell was dropped
//   frames_sent       number of tlast handshakes, wrapping
// ---------------------------------------------------------------------------
module lbm_frame_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 2500,
    parameter int FIFO_DEPTH = 64,
    parameter int DECIM_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [DECIM_W-1:0]               decim,
    input  logic [NUM_CH-1:0]                ch_mask,
    input  logic                             frame_start,
    input  logic                             cell_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     cell_data,
    output logic                             m_axis_tvalid,
    output logic [NUM_CH*DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [NUM_CH*DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic                             busy,
    output logic                             overflow,
    output logic [DECIM_W-1:0]               frames_sent
);

    localparam int DW_ALL  = NUM_CH * DATA_WIDTH;
    localparam int LANE_B  = DATA_WIDTH / 8;
    localparam int STRB_W  = DW_ALL / 8;
    localparam int CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W   = DW_ALL + STRB_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Zero every lane whose mask bit is clear.
    function automatic logic [DW_ALL-1:0] mask_lanes(
        input logic [DW_ALL-1:0] data,
        input logic [NUM_CH-1:0] mask
    );
        logic [DW_ALL-1:0] res;
        res = {DW_ALL{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (mask[k]) begin
                res[k*DATA_WIDTH +: DATA_WIDTH] = data[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                res[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
        return res;
    endfunction

    // Expand the channel mask to byte strobes (LANE_B bits per lane).
    function automatic logic [STRB_W-1:0] strb_from_mask(input logic [NUM_CH-1:0] mask);
        logic [STRB_W-1:0] res;
        res = {STRB_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            res[k*LANE_B +: LANE_B] = {LANE_B{mask[k]}};
        end
        return res;
    endfunction

    // Registers
    state_t               state_r;
    logic [DECIM_W-1:0]   decim_cnt_r;
    logic [CNT_W-1:0]     cell_cnt_r;
    logic [ENT_W-1:0]     fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic                 tvalid_r;
    logic [DW_ALL-1:0]    tdata_r;
    logic [STRB_W-1:0]    tstrb_r;
    logic                 tlast_r;
    logic                 overflow_r;
    logic [DECIM_W-1:0]   frames_sent_r;
    logic                 busy_r;

    // Next-state / control signals
    state_t               state_nxt_s;
    logic [DECIM_W-1:0]   decim_cnt_nxt_s;
    logic [CNT_W-1:0]     cell_cnt_nxt_s;
    logic [PTR_W:0]       count_nxt_s;
    logic                 tvalid_nxt_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 cell_take_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 last_cell_s;
    logic                 hs_s;
    logic [ENT_W-1:0]     push_entry_s;
    logic [ENT_W-1:0]     head_entry_s;

    // FIFO status, handshake and push/pop qualification.
    always_comb begin
        fifo_full_s  = (count_r == (PTR_W+1)'(FIFO_DEPTH));
        fifo_empty_s = (count_r == {(PTR_W+1){1'b0}});
        hs_s         = tvalid_r & m_axis_tready;
        // Output register refills when empty or when its beat is leaving.
        pop_s        = ~fifo_empty_s & (~tvalid_r | m_axis_tready);
        cell_take_s  = (state_r == ST_CAPTURE) & en & cell_valid;
        // A full FIFO still accepts when a pop frees a slot in the same cycle.
        push_s       = cell_take_s & (~fifo_full_s | pop_s);
        drop_s       = cell_take_s & ~push_s;
        last_cell_s  = (cell_cnt_r == CNT_W'(DEPTH - 1));
        push_entry_s = {last_cell_s, strb_from_mask(ch_mask), mask_lanes(cell_data, ch_mask)};
        head_entry_s = fifo_mem_r[rd_ptr_r];
        count_nxt_s  = count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
        if (pop_s) begin
            tvalid_nxt_s = 1'b1;
        end else if (hs_s) begin
            tvalid_nxt_s = 1'b0;
        end else begin
            tvalid_nxt_s = tvalid_r;
        end
    end

    // Frame FSM: decimation, cell counting, drain tracking.
    always_comb begin
        state_nxt_s     = state_r;
        decim_cnt_nxt_s = decim_cnt_r;
        cell_cnt_nxt_s  = cell_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (en && frame_start) begin
                    if (decim_cnt_r == {DECIM_W{1'b0}}) begin
                        decim_cnt_nxt_s = decim;
                        cell_cnt_nxt_s  = {CNT_W{1'b0}};
                        state_nxt_s     = ST_CAPTURE;
                    end else begin
                        decim_cnt_nxt_s = decim_cnt_r - DECIM_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // Dropped cells still advance the count so tlast stays aligned.
                if (cell_take_s) begin
                    if (last_cell_s) begin
                        cell_cnt_nxt_s = {CNT_W{1'b0}};
                        state_nxt_s    = ST_DRAIN;
                    end else begin
                        cell_cnt_nxt_s = cell_cnt_r + CNT_W'(1);
                    end
                end else begin
                    cell_cnt_nxt_s = cell_cnt_r;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && !tvalid_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, FIFO pointers and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            decim_cnt_r   <= {DECIM_W{1'b0}};
            cell_cnt_r    <= {CNT_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {(PTR_W+1){1'b0}};
            overflow_r    <= 1'b0;
            frames_sent_r <= {DECIM_W{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            decim_cnt_r <= decim_cnt_nxt_s;
            cell_cnt_r  <= cell_cnt_nxt_s;
            count_r     <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (hs_s && tlast_r) begin
                frames_sent_r <= frames_sent_r + DECIM_W'(1);
            end
            // Computed from next-state values so busy matches the registered state.
            busy_r <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {(PTR_W+1){1'b0}})
                      || tvalid_nxt_s;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // AXIS output register; holds its beat while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_r <= 1'b0;
            tdata_r  <= {DW_ALL{1'b0}};
            tstrb_r  <= {STRB_W{1'b0}};
            tlast_r  <= 1'b0;
        end else begin
            tvalid_r <= tvalid_nxt_s;
            if (pop_s) begin
                tdata_r <= head_entry_s[DW_ALL-1:0];
                tstrb_r <= head_entry_s[DW_ALL +: STRB_W];
                tlast_r <= head_entry_s[ENT_W-1];
            end
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tstrb  = tstrb_r;
    assign m_axis_tlast  = tlast_r;
    assign busy          = busy_r;
    assign overflow      = overflow_r;
    assign frames_sent   = frames_sent_r;

endmodule
